// File: rtl/ddr_note_scheduler_if.sv
// Handshake bundle between the note scheduler and the game-level logic around it:
// player inputs and point codes in, column drives, score and game status out.
interface ddr_note_scheduler_if;
   logic        start;
   logic [3:0]  key;
   logic [15:0] pt_in;
   logic [3:0]  spawn;
   logic        step;
   logic [11:0] top_pos;
   logic [9:0]  score;
   logic [7:0]  notes_left;
   logic [1:0]  state;
   logic        game_over;

   modport master (
      output start, key, pt_in,
      input  spawn, step, top_pos, score, notes_left, state, game_over
   );

   modport slave (
      input  start, key, pt_in,
      output spawn, step, top_pos, score, notes_left, state, game_over
   );
endinterface

// File: rtl/ddr_note_scheduler.sv
// Game sequencer for four 5-light note columns: paces steps, spawns notes from an LFSR,
// tracks shadow occupancy for TOP_POS, handles key hits and keeps the saturating score.
module ddr_note_scheduler #(
   parameter int         STEP_CYCLES = 50,
   parameter int         NUM_NOTES   = 64,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   parameter int         LOSE_SCORE  = -32
) (
   input logic                  clk,
   input logic                  rst_n,
   ddr_note_scheduler_if.slave  bus
);

   localparam int                CW        = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0]     CNT_LAST  = CW'(STEP_CYCLES - 1);
   localparam logic signed [11:0] LOSE_LIM = 12'(LOSE_SCORE);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t             st;
   logic [CW-1:0]      cnt;
   logic [7:0]         lfsr;
   logic [3:0][4:0]    occ;
   logic [3:0]         key_prev;
   logic signed [9:0]  score_q;
   logic [7:0]         notes_left_q;
   logic [3:0]         spawn_q;
   logic               step_q;
   logic               game_over_q;

   logic               step_now;
   logic [7:0]         lfsr_shift;
   logic [3:0]         rise;
   logic [3:0]         spawn_vec;
   logic [3:0][4:0]    occ_hit;
   logic [3:0][4:0]    occ_next;
   logic [2:0]         miss_cnt;
   logic signed [11:0] pt_sum;
   logic signed [11:0] score_ext;
   logic signed [11:0] miss_ext;
   logic signed [11:0] sum;
   logic signed [9:0]  score_next;
   logic               terminal;
   logic [11:0]        top_pos_c;

   function automatic logic [2:0] top_code(input logic [4:0] o);
      logic [2:0] t;
      t = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (o[i]) t = 3'(i + 1);
      end
      return t;
   endfunction

   function automatic logic [4:0] clear_top(input logic [4:0] o);
      logic [4:0] r;
      logic       found;
      r     = o;
      found = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         if (!found && o[i]) begin
            r[i]  = 1'b0;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Hits act on the pre-shift column, so a note cleared from the top light never counts as a miss.
   always_comb begin
      step_now   = (st == PLAY) && (cnt == CNT_LAST);
      lfsr_shift = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      rise       = bus.key & ~key_prev;
      spawn_vec  = 4'd0;
      if (step_now && (notes_left_q != 8'd0) && lfsr_shift[2]) begin
         spawn_vec[lfsr_shift[1:0]] = 1'b1;
      end
      miss_cnt = 3'd0;
      pt_sum   = 12'sd0;
      occ_hit  = occ;
      occ_next = occ;
      for (int c = 0; c < 4; c++) begin
         occ_hit[c]  = rise[c] ? clear_top(occ[c]) : occ[c];
         occ_next[c] = step_now ? {occ_hit[c][3:0], spawn_vec[c]} : occ_hit[c];
         miss_cnt    = miss_cnt + {2'd0, step_now & occ_hit[c][4]};
         pt_sum      = pt_sum + {{8{bus.pt_in[4*c+3]}}, bus.pt_in[4*c +: 4]};
      end
      score_ext = {{2{score_q[9]}}, score_q};
      miss_ext  = {9'd0, miss_cnt};
      sum       = score_ext + pt_sum - miss_ext;
      if (sum > 12'sd511) begin
         score_next = 10'sd511;
      end else if (sum < -12'sd512) begin
         score_next = -10'sd512;
      end else begin
         score_next = sum[9:0];
      end
      terminal = ((notes_left_q == 8'd0) && (occ == '0)) || (score_ext <= LOSE_LIM);
   end

   always_comb begin
      top_pos_c = 12'd0;
      for (int c = 0; c < 4; c++) begin
         top_pos_c[3*c +: 3] = top_code(occ[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= IDLE;
         cnt          <= '0;
         lfsr         <= LFSR_SEED;
         occ          <= '0;
         key_prev     <= 4'd0;
         score_q      <= 10'sd0;
         notes_left_q <= 8'd0;
         spawn_q      <= 4'd0;
         step_q       <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         step_q   <= 1'b0;
         spawn_q  <= 4'd0;
         key_prev <= bus.key;
         case (st)
            IDLE, DONE: begin
               if (bus.start) begin
                  st           <= PLAY;
                  game_over_q  <= 1'b0;
                  score_q      <= 10'sd0;
                  notes_left_q <= 8'(NUM_NOTES);
                  cnt          <= '0;
                  occ          <= '0;
                  key_prev     <= 4'd0;
               end
            end
            PLAY: begin
               cnt     <= step_now ? '0 : cnt + 1'b1;
               occ     <= occ_next;
               score_q <= score_next;
               if (step_now) begin
                  step_q  <= 1'b1;
                  spawn_q <= spawn_vec;
                  lfsr    <= lfsr_shift;
                  if (|spawn_vec) notes_left_q <= notes_left_q - 8'd1;
               end
               if (terminal) begin
                  st          <= DONE;
                  game_over_q <= 1'b1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.spawn      = spawn_q;
   assign bus.step       = step_q;
   assign bus.top_pos    = top_pos_c;
   assign bus.score      = score_q;
   assign bus.notes_left = notes_left_q;
   assign bus.state      = st;
   assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_ddr_note_scheduler.sv
// Bench for ddr_note_scheduler: a note-list reference model is advanced every clock and
// every output is compared after each edge, plus directed timing, lose, saturation and reset checks.
module tb_ddr_note_scheduler;

   localparam int S    = 4;
   localparam int N    = 8;
   localparam int LOSE = -32;

   logic clk = 1'b0;
   logic rst_n;

   ddr_note_scheduler_if bus();

   ddr_note_scheduler #(
      .STEP_CYCLES(S),
      .NUM_NOTES  (N),
      .LFSR_SEED  (8'hA5),
      .LOSE_SCORE (LOSE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int col;
      int pos;
   } note_t;

   note_t      notes[$];
   int         m_phase;
   int         m_cnt;
   int         m_lfsr;
   int         m_score;
   int         m_left;
   int         m_over;
   int         m_step;
   int         m_spawn;
   logic [3:0] m_kprev;
   int         n_pass  = 0;
   int         n_total = 0;

   function automatic int top_of(int c);
      int t;
      t = 0;
      foreach (notes[i]) begin
         if (notes[i].col == c && notes[i].pos + 1 > t) t = notes[i].pos + 1;
      end
      return t;
   endfunction

   function automatic logic [15:0] rand_pt();
      logic [15:0] p;
      int          r;
      p = 16'd0;
      for (int c = 0; c < 4; c++) begin
         r = $urandom_range(0, 9);
         if (r == 0) p[4*c +: 4] = 4'hF;
         else if (r == 1) p[4*c +: 4] = 4'h1;
      end
      return p;
   endfunction

   task automatic model_reset();
      notes.delete();
      m_phase = 0;
      m_cnt   = 0;
      m_lfsr  = 8'hA5;
      m_score = 0;
      m_left  = 0;
      m_over  = 0;
      m_step  = 0;
      m_spawn = 0;
      m_kprev = 4'd0;
   endtask

   // Advances the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      int         misses;
      int         sum;
      int         v;
      int         hi;
      int         idx;
      int         newbit;
      int         term;
      logic [3:0] rise;
      note_t      nn;
      m_step  = 0;
      m_spawn = 0;
      if (m_phase != 1) begin
         m_kprev = bus.key;
         if (bus.start) begin
            m_phase = 1;
            m_score = 0;
            m_left  = N;
            m_cnt   = 0;
            m_over  = 0;
            m_kprev = 4'd0;
            notes.delete();
         end
      end else begin
         term = ((m_left == 0 && notes.size() == 0) || (m_score <= LOSE)) ? 1 : 0;
         rise = bus.key & ~m_kprev;
         for (int c = 0; c < 4; c++) begin
            if (rise[c]) begin
               hi  = -1;
               idx = -1;
               foreach (notes[i]) begin
                  if (notes[i].col == c && notes[i].pos > hi) begin
                     hi  = notes[i].pos;
                     idx = i;
                  end
               end
               if (idx >= 0) notes.delete(idx);
            end
         end
         misses = 0;
         if (m_cnt == S - 1) begin
            newbit = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) & 255) | newbit;
            foreach (notes[i]) notes[i].pos = notes[i].pos + 1;
            for (int i = notes.size() - 1; i >= 0; i--) begin
               if (notes[i].pos > 4) begin
                  notes.delete(i);
                  misses++;
               end
            end
            if (m_left > 0 && ((m_lfsr >> 2) & 1) == 1) begin
               nn.col = m_lfsr & 3;
               nn.pos = 0;
               notes.push_back(nn);
               m_left--;
               m_spawn = 1 << (m_lfsr & 3);
            end
            m_step = 1;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
         sum = m_score - misses;
         for (int c = 0; c < 4; c++) begin
            v = (bus.pt_in >> (4 * c)) & 15;
            if (v > 7) v = v - 16;
            sum = sum + v;
         end
         if (sum > 511) sum = 511;
         if (sum < -512) sum = -512;
         m_score = sum;
         m_kprev = bus.key;
         if (term == 1) begin
            m_phase = 2;
            m_over  = 1;
         end
      end
   endtask

   task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
      n_total++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("[TB] FAIL %s: observed %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("state", {30'd0, bus.state}, m_phase);
      check("game_over", {31'd0, bus.game_over}, m_over);
      check("step", {31'd0, bus.step}, m_step);
      check("spawn", {28'd0, bus.spawn}, m_spawn);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("top_pos%0d", c), {29'd0, bus.top_pos[3*c +: 3]}, top_of(c));
      end
      check("score", {{22{bus.score[9]}}, bus.score}, m_score);
      check("notes_left", {24'd0, bus.notes_left}, m_left);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      logic hit_a;
      logic hit_b;
      int   guard;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.key   = 4'd0;
      bus.pt_in = 16'd0;
      model_reset();
      #12;
      check_outputs();
      rst_n = 1'b1;

      // Idle: keys and points must be ignored, no step pulses.
      for (int i = 0; i < 200; i++) begin
         bus.key   = 4'($urandom_range(0, 15));
         bus.pt_in = 16'($urandom);
         tick();
      end

      // Game 1: step cadence, then random keys and small point codes.
      bus.key   = 4'd0;
      bus.pt_in = 16'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("step_period", {31'd0, bus.step}, (k == 4) ? 1 : 0);
      end
      guard = 0;
      while (m_phase != 2 && guard < 400) begin
         bus.key   = 4'($urandom_range(0, 15));
         bus.pt_in = rand_pt();
         tick();
         guard++;
      end
      check("game1_done", {30'd0, bus.state}, 2);

      // Game 2: targeted hits on a note at TOP_POS 3 and on a top-light note during a step.
      bus.key   = 4'd0;
      bus.pt_in = 16'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      hit_a = 1'b0;
      hit_b = 1'b0;
      guard = 0;
      while (m_phase != 2 && guard < 400) begin
         for (int c = 0; c < 4; c++) begin
            if (!hit_a && !bus.key[c] && top_of(c) == 3) begin
               bus.key[c] = 1'b1;
               hit_a      = 1'b1;
            end else if (!hit_b && !bus.key[c] && top_of(c) == 5 && m_cnt == S - 1) begin
               bus.key[c] = 1'b1;
               hit_b      = 1'b1;
            end
         end
         tick();
         guard++;
      end
      check("game2_done", {30'd0, bus.state}, 2);

      // Game 3: -2 on every column loses the game after the score reaches -32.
      bus.key   = 4'd0;
      bus.pt_in = 16'hEEEE;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("lose_state", {30'd0, bus.state}, 2);
      check("lose_score", {{22{bus.score[9]}}, bus.score}, -40);
      check("lose_over", {31'd0, bus.game_over}, 1);

      // Game 4: restart, then +7 on every column saturates the score.
      bus.start = 1'b1;
      tick();
      check("restart_score", {{22{bus.score[9]}}, bus.score}, 0);
      check("restart_state", {30'd0, bus.state}, 1);
      bus.start = 1'b0;
      bus.pt_in = 16'h7777;
      for (int i = 0; i < 30; i++) tick();
      check("sat_score", {{22{bus.score[9]}}, bus.score}, 511);
      check("sat_state", {30'd0, bus.state}, 1);

      // Asynchronous reset in the middle of play.
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs();
      check("async_rst_score", {{22{bus.score[9]}}, bus.score}, 0);
      @(posedge clk);
      #1;
      check_outputs();
      rst_n     = 1'b1;
      bus.pt_in = 16'd0;
      for (int i = 0; i < 10; i++) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
